jt12_wrseq: RTL and testbench



---
 rtl/jt12_wrseq_pkg.sv | 26 ++
 rtl/jt12_wrseq_fifo.sv | 57 +++++
 rtl/jt12_wrseq.sv | 200 ++++++++++++++++++++
 tb/tb_jt12_wrseq.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jt12_wrseq_pkg.sv
// Shared definitions for the jt12 register write sequencer: FSM state encodings and the
// layout of a queued request entry {bank, reg, val}.
package jt12_wrseq_pkg;

    localparam int unsigned EntW    = 17;
    localparam int unsigned ValLsb  = 0;
    localparam int unsigned RegLsb  = 8;
    localparam int unsigned BankBit = 16;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StAWr   = 3'd1,
        StARel  = 3'd2,
        StAWait = 3'd3,
        StDWr   = 3'd4,
        StDRel  = 3'd5,
        StDWait = 3'd6
    } state_e;

    function automatic logic [EntW-1:0] pack_entry(input logic       bank,
                                                   input logic [7:0] rg,
                                                   input logic [7:0] val);
        return {bank, rg, val};
    endfunction

endpackage

// File: rtl/jt12_wrseq_fifo.sv
// Request FIFO for the write sequencer: synchronous, first-word-fall-through head,
// occupancy count. Runs every clock.
module jt12_wrseq_fifo #(
    parameter int unsigned AW = 3,
    parameter int unsigned W  = 17
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [W-1:0]  din_i,
    output logic [W-1:0]  head_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   count_o
);

    localparam int unsigned Depth = 1 << AW;
    localparam int unsigned CW    = AW + 1;

    logic [W-1:0]  mem_q [Depth];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push, do_pop;

    assign full_o  = (count_q == CW'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // Fullness comes from the registered count, so a same-cycle pop never makes room.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/jt12_wrseq.sv
// Host-side write sequencer for the jt12 two-port register interface: queues writes and replays
// each as an address strobe then a data strobe. JT12_WRSEQ_ACACHE_EN skips repeated addresses.
module jt12_wrseq
    import jt12_wrseq_pkg::*;
#(
    parameter int unsigned FIFO_AW = 3,
    parameter int unsigned HOLD    = 2,
    parameter int unsigned TOUT    = 255
) (
    input  logic             rst,
    input  logic             clk,
    input  logic             cen,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_bank,
    input  logic [7:0]       req_reg,
    input  logic [7:0]       req_val,
    output logic [1:0]       addr,
    output logic [7:0]       dout,
    output logic             write,
    input  logic             busy,
    output logic             idle,
    output logic [FIFO_AW:0] pending,
    output logic             timeout,
    input  logic             clr_timeout
);

    localparam int unsigned CW = FIFO_AW + 1;
    localparam int unsigned HW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam int unsigned TW = (TOUT > 1) ? $clog2(TOUT) : 1;

    state_e            state_q, state_d;
    logic [HW-1:0]     hold_q, hold_d;
    logic [TW-1:0]     tout_q, tout_d;
    logic [EntW-1:0]   ent_q, ent_d;
    logic [1:0]        addr_q, addr_d;
    logic [7:0]        dout_q, dout_d;
    logic              write_q, write_d;
    logic              timeout_q, timeout_d;
    logic              idle_q, idle_d;

    logic              push_en, pop, start, tout_hit, cache_hit;
    logic              fifo_full, fifo_empty;
    logic [EntW-1:0]   fifo_head;
    logic [CW-1:0]     cnt_nx;

    assign req_ready = !fifo_full && !rst;
    assign push_en   = req_valid && req_ready;

    jt12_wrseq_fifo #(
        .AW (FIFO_AW),
        .W  (EntW)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (push_en),
        .pop_i   (pop),
        .din_i   (pack_entry(req_bank, req_reg, req_val)),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (pending)
    );

`ifdef JT12_WRSEQ_ACACHE_EN
    logic       cache_vld_q, tout_seen_q;
    logic [8:0] cache_tag_q;

    assign cache_hit = cache_vld_q && (cache_tag_q == fifo_head[BankBit:RegLsb]);

    // A timeout anywhere in an entry leaves the chip's address latch unknown.
    always_ff @(posedge clk) begin
        if (rst) begin
            cache_vld_q <= 1'b0;
            tout_seen_q <= 1'b0;
            cache_tag_q <= '0;
        end else if (tout_hit) begin
            cache_vld_q <= 1'b0;
            tout_seen_q <= 1'b1;
        end else if (start) begin
            tout_seen_q <= 1'b0;
        end else if (pop) begin
            cache_vld_q <= !tout_seen_q;
            cache_tag_q <= ent_q[BankBit:RegLsb];
        end
    end
`else
    assign cache_hit = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        tout_d   = tout_q;
        ent_d    = ent_q;
        addr_d   = addr_q;
        dout_d   = dout_q;
        write_d  = write_q;
        pop      = 1'b0;
        start    = 1'b0;
        tout_hit = 1'b0;
        if (cen) begin
            unique case (state_q)
                StIdle: begin
                    if (!fifo_empty) begin
                        start   = 1'b1;
                        ent_d   = fifo_head;
                        hold_d  = '0;
                        write_d = 1'b1;
                        if (cache_hit) begin
                            state_d = StDWr;
                            addr_d  = {fifo_head[BankBit], 1'b1};
                            dout_d  = fifo_head[ValLsb +: 8];
                        end else begin
                            state_d = StAWr;
                            addr_d  = {fifo_head[BankBit], 1'b0};
                            dout_d  = fifo_head[RegLsb +: 8];
                        end
                    end
                end
                StAWr, StDWr: begin
                    if (hold_q == HW'(HOLD - 1)) begin
                        state_d = (state_q == StAWr) ? StARel : StDRel;
                        write_d = 1'b0;
                    end else begin
                        hold_d = hold_q + HW'(1);
                    end
                end
                StARel, StDRel: begin
                    state_d = (state_q == StARel) ? StAWait : StDWait;
                    tout_d  = '0;
                end
                StAWait, StDWait: begin
                    // An expired wait proceeds exactly as if busy had been seen low.
                    if (!busy || tout_q == TW'(TOUT - 1)) begin
                        tout_hit = busy;
                        if (state_q == StAWait) begin
                            state_d = StDWr;
                            hold_d  = '0;
                            addr_d  = {ent_q[BankBit], 1'b1};
                            dout_d  = ent_q[ValLsb +: 8];
                            write_d = 1'b1;
                        end else begin
                            state_d = StIdle;
                            pop     = 1'b1;
                        end
                    end else begin
                        tout_d = tout_q + TW'(1);
                    end
                end
                default: begin
                    state_d = StIdle;
                    write_d = 1'b0;
                end
            endcase
        end

        timeout_d = timeout_q;
        if (clr_timeout) begin
            timeout_d = 1'b0;
        end
        if (tout_hit) begin
            timeout_d = 1'b1;
        end

        cnt_nx = pending + CW'(push_en) - CW'(pop);
        idle_d = (cnt_nx == '0) && (state_d == StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            hold_q    <= '0;
            tout_q    <= '0;
            ent_q     <= '0;
            addr_q    <= '0;
            dout_q    <= '0;
            write_q   <= 1'b0;
            timeout_q <= 1'b0;
            idle_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            tout_q    <= tout_d;
            ent_q     <= ent_d;
            addr_q    <= addr_d;
            dout_q    <= dout_d;
            write_q   <= write_d;
            timeout_q <= timeout_d;
            idle_q    <= idle_d;
        end
    end

    assign addr    = addr_q;
    assign dout    = dout_q;
    assign write   = write_q;
    assign timeout = timeout_q;
    assign idle    = idle_q;

endmodule

// File: tb/tb_jt12_wrseq.sv
// Self-checking bench for jt12_wrseq: directed scenarios plus randomized traffic, compared
// against an expected bus-strobe list derived from each accepted request.
module tb_jt12_wrseq;

    localparam int unsigned FIFO_AW = 3;
    localparam int unsigned HOLD    = 2;
    localparam int unsigned TOUT    = 255;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cen = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_bank = 1'b0;
    logic [7:0]       req_reg = 8'h00;
    logic [7:0]       req_val = 8'h00;
    logic             busy = 1'b0;
    logic             clr_timeout = 1'b0;
    logic             req_ready, write, idle, timeout;
    logic [1:0]       addr;
    logic [7:0]       dout;
    logic [FIFO_AW:0] pending;

    int errors = 0;
    int checks = 0;
    int cen_div = 1;
    int busy_mode = 0;   // 0: low, 1: pulse after each write rise, 2: stuck high
    int pulses = 0;

    // Expected bus strobes, each {addr, dout}, in issue order.
    logic [9:0] exp_q[$];
`ifdef JT12_WRSEQ_ACACHE_EN
    logic       mc_vld = 1'b0;
    logic [8:0] mc_tag = 9'd0;
`endif

    jt12_wrseq #(
        .FIFO_AW (FIFO_AW),
        .HOLD    (HOLD),
        .TOUT    (TOUT)
    ) dut (
        .rst         (rst),
        .clk         (clk),
        .cen         (cen),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_bank    (req_bank),
        .req_reg     (req_reg),
        .req_val     (req_val),
        .addr        (addr),
        .dout        (dout),
        .write       (write),
        .busy        (busy),
        .idle        (idle),
        .pending     (pending),
        .timeout     (timeout),
        .clr_timeout (clr_timeout)
    );

    initial forever #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_push(input logic b, input logic [7:0] r, input logic [7:0] v);
`ifdef JT12_WRSEQ_ACACHE_EN
        if (!(mc_vld && mc_tag == {b, r})) begin
            exp_q.push_back({b, 1'b0, r});
        end
        mc_vld = 1'b1;
        mc_tag = {b, r};
`else
        exp_q.push_back({b, 1'b0, r});
`endif
        exp_q.push_back({b, 1'b1, v});
    endfunction

    function automatic void model_invalidate();
`ifdef JT12_WRSEQ_ACACHE_EN
        mc_vld = 1'b0;
`endif
    endfunction

    // Called at a negedge; returns at the negedge after acceptance with req_valid still high.
    task automatic push(input logic b, input logic [7:0] r, input logic [7:0] v);
        int n = 0;
        req_valid = 1'b1;
        req_bank  = b;
        req_reg   = r;
        req_val   = v;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq("push_accept", {31'd0, req_ready}, 32'd1);
        if (req_ready) begin
            @(posedge clk);
            model_push(b, r, v);
            @(negedge clk);
        end
    endtask

    task automatic drop();
        req_valid = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!idle && n < 3000);
        check_eq("idle_reached", {31'd0, idle}, 32'd1);
    endtask

    task automatic wait_first_fall();
        int n = 0;
        while (!write && n < 500) begin
            @(negedge clk);
            n++;
        end
        while (write && n < 500) begin
            @(negedge clk);
            n++;
        end
        check_eq("strobe_seen", {31'd0, n < 500}, 32'd1);
    endtask

    initial begin : cen_gen
        int ccnt = 0;
        forever begin
            @(negedge clk);
            ccnt++;
            if (ccnt >= cen_div) ccnt = 0;
            cen = (ccnt == 0);
        end
    end

    initial begin : busy_gen
        logic pw = 1'b0;
        int   dly = 0;
        int   blen = 0;
        forever begin
            @(negedge clk);
            if (busy_mode == 2) begin
                busy = 1'b1;
            end else if (busy_mode == 0) begin
                busy = 1'b0;
                dly  = 0;
                blen = 0;
            end else begin
                if (write && !pw) dly = 3;
                if (blen > 0) begin
                    blen--;
                    if (blen == 0) busy = 1'b0;
                end
                if (dly > 0) begin
                    dly--;
                    if (dly == 0) begin
                        busy = 1'b1;
                        blen = $urandom_range(1, 6);
                    end
                end
            end
            pw = write;
        end
    end

    initial begin : bus_mon
        logic       in_p = 1'b0;
        logic [9:0] cur = 10'd0;
        int         len = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                in_p = 1'b0;
                len  = 0;
            end else if (write && !in_p) begin
                in_p = 1'b1;
                len  = 1;
                pulses++;
                cur  = {addr, dout};
                check_eq("strobe_expected", {31'd0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) begin
                    check_eq("strobe_bus", {22'd0, cur}, {22'd0, exp_q.pop_front()});
                end
            end else if (write && in_p) begin
                len++;
                check_eq("bus_stable", {22'd0, addr, dout}, {22'd0, cur});
            end else if (!write && in_p) begin
                in_p = 1'b0;
                check_eq("strobe_len", len, HOLD * cen_div);
            end
        end
    end

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        int n;
        int p0;
        logic       b;
        logic [7:0] r, v;

        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_write", {31'd0, write}, 32'd0);
        check_eq("rst_addr", {30'd0, addr}, 32'd0);
        check_eq("rst_dout", {24'd0, dout}, 32'd0);
        check_eq("rst_idle", {31'd0, idle}, 32'd1);
        check_eq("rst_pending", {28'd0, pending}, 32'd0);
        check_eq("rst_timeout", {31'd0, timeout}, 32'd0);
        check_eq("rst_ready", {31'd0, req_ready}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("ready_after_rst", {31'd0, req_ready}, 32'd1);

        // Single write with busy pulsing after each strobe.
        busy_mode = 1;
        p0 = pulses;
        push(1'b0, 8'h28, 8'hF1);
        drop();
        check_eq("busy_not_idle", {31'd0, idle}, 32'd0);
        wait_idle(n);
        check_eq("single_pulses", pulses - p0, 2);
        check_eq("single_pending", {28'd0, pending}, 32'd0);

        // Minimum latency with busy never high.
        busy_mode = 0;
        push(1'b1, 8'h30, 8'h07);
        drop();
        wait_idle(n);
        check_eq("min_latency", n, 9);

        // Fill the FIFO back to back.
        for (int i = 0; i < 8; i++) begin
            push(1'(i % 2), 8'(8'h50 + i), 8'(i * 3));
        end
        check_eq("fill_pending", {28'd0, pending}, 32'd8);
        check_eq("fill_ready", {31'd0, req_ready}, 32'd0);
        push(1'b1, 8'h60, 8'hAA);
        drop();
        wait_idle(n);
        check_eq("fill_drained", exp_q.size(), 0);

        // Slow cen: strobes last HOLD cen periods.
        cen_div = 6;
        push(1'b0, 8'hB0, 8'h3C);
        drop();
        wait_idle(n);
        cen_div = 1;

        // Stuck busy: both waits expire.
        busy_mode = 2;
        push(1'b1, 8'h40, 8'h55);
        drop();
        wait_first_fall();
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!timeout && n < 400);
        check_eq("tout_latency", n, TOUT + 1);
        check_eq("tout_data_strobe", {30'd0, write, addr[0]}, 32'd3);
        wait_idle(n);
        check_eq("tout_sticky", {31'd0, timeout}, 32'd1);
        clr_timeout = 1'b1;
        @(negedge clk);
        clr_timeout = 1'b0;
        check_eq("tout_cleared", {31'd0, timeout}, 32'd0);
        model_invalidate();

        // Set and clear on the same edge: set wins.
        push(1'b0, 8'h41, 8'h66);
        drop();
        wait_first_fall();
        repeat (TOUT) @(negedge clk);
        check_eq("tout_not_yet", {31'd0, timeout}, 32'd0);
        clr_timeout = 1'b1;
        @(negedge clk);
        clr_timeout = 1'b0;
        check_eq("tout_set_wins", {31'd0, timeout}, 32'd1);
        busy_mode = 0;
        wait_idle(n);
        check_eq("tout_kept", {31'd0, timeout}, 32'd1);
        clr_timeout = 1'b1;
        @(negedge clk);
        clr_timeout = 1'b0;
        check_eq("tout_cleared2", {31'd0, timeout}, 32'd0);
        model_invalidate();

        // Reset during the data strobe.
        push(1'b0, 8'h10, 8'h99);
        drop();
        n = 0;
        while (!(write && addr[0]) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq("dwr_reached", {31'd0, n < 200}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        model_invalidate();
        @(negedge clk);
        check_eq("midrst_write", {31'd0, write}, 32'd0);
        check_eq("midrst_pending", {28'd0, pending}, 32'd0);
        check_eq("midrst_idle", {31'd0, idle}, 32'd1);
        check_eq("midrst_ready", {31'd0, req_ready}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        p0 = pulses;
        push(1'b1, 8'h22, 8'h44);
        drop();
        wait_idle(n);
        check_eq("postrst_pulses", pulses - p0, 2);

        // Repeated address.
        p0 = pulses;
        push(1'b0, 8'hA4, 8'h11);
        drop();
        wait_idle(n);
        check_eq("a4_first_pulses", pulses - p0, 2);
        p0 = pulses;
        push(1'b0, 8'hA4, 8'h12);
        drop();
        wait_idle(n);
`ifdef JT12_WRSEQ_ACACHE_EN
        check_eq("a4_second_pulses", pulses - p0, 1);
`else
        check_eq("a4_second_pulses", pulses - p0, 2);
`endif

        // Randomized traffic.
        for (int ph = 0; ph < 2; ph++) begin
            cen_div   = (ph == 0) ? 1 : 3;
            busy_mode = 1;
            for (int i = 0; i < 25; i++) begin
                b = 1'($urandom_range(0, 1));
                case ($urandom_range(0, 3))
                    0:       r = 8'h28;
                    1:       r = 8'hA4;
                    2:       r = 8'hB4;
                    default: r = 8'($urandom_range(0, 255));
                endcase
                v = 8'($urandom_range(0, 255));
                push(b, r, v);
                if ($urandom_range(0, 2) == 0) begin
                    drop();
                    repeat ($urandom_range(1, 12)) @(negedge clk);
                end
            end
            drop();
            wait_idle(n);
            check_eq("rand_drained", exp_q.size(), 0);
            check_eq("rand_pending", {28'd0, pending}, 32'd0);
        end
        busy_mode = 0;
        cen_div   = 1;
        check_eq("final_timeout", {31'd0, timeout}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
